uart_flowctl_core: RTL and testbench

Parametrised UART engine, the next generation of the team's tapeout UART.
- Configurable data width, run-time baud divisor, TX and RX FIFOs of parametric depth.
- RTS/CTS hardware flow control and sticky per-type error flags.
- Sits between a valid/ready byte interface (wrapper or AHB bridge) and the rx/tx/cts/rts pins.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 56 +++++
 rtl/uart_flowctl_core.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_flowctl_core.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encodings, parity modes and error bit indices
//               for the flow-controlled UART core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_PARITY  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with show-ahead read data and fill count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_full,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_count == c_FULL);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_flowctl_core.sv
// ============================================================================
// Module      : uart_flowctl_core
// Description : UART engine with TX/RX FIFOs, RTS/CTS flow control and
//               sticky error flags. Optional parity via UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_flowctl_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int DIV_W      = 16,
    parameter int RTS_MARGIN = 2
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              rx,
    output logic              tx,
    input  logic              cts,
    output logic              rts,
`ifdef UART_PARITY_EN
    input  logic [1:0]        parity_mode,
`endif
    input  logic              err_clr,
    output logic [2:0]        err_flags,
    output logic              err,
    output logic              tx_busy
);

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_BW = $clog2(DATA_W);
    localparam logic [c_BW-1:0] c_LAST   = c_BW'(DATA_W - 1);
    localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_MARGIN = c_CW'(RTS_MARGIN);

    logic r_init, r_rts;
    logic r_cts_s1, r_cts_s2;
    logic r_rx_s1, r_rx_s2, r_rx_s3;
    logic [2:0] r_err;

    // ---------------- FIFOs ----------------
    logic              w_tx_full, w_tx_empty, w_tx_pop;
    logic [DATA_W-1:0] w_tx_head;
    logic [c_CW-1:0]   w_tx_count;
    logic              w_rx_full, w_rx_empty, w_rx_push;
    logic [c_CW-1:0]   w_rx_count;
    logic [DATA_W-1:0] r_rx_shift;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .nReset(nReset),
        .i_push(tx_valid & tx_ready), .i_data(tx_data), .o_full(w_tx_full),
        .i_pop(w_tx_pop), .o_data(w_tx_head), .o_empty(w_tx_empty),
        .o_count(w_tx_count)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .nReset(nReset),
        .i_push(w_rx_push), .i_data(r_rx_shift), .o_full(w_rx_full),
        .i_pop(rx_ready), .o_data(rx_data), .o_empty(w_rx_empty),
        .o_count(w_rx_count)
    );

    assign tx_ready  = r_init & ~w_tx_full;
    assign rx_valid  = ~w_rx_empty;
    assign rts       = r_rts;
    assign err_flags = r_err;
    assign err       = |r_err;

    // ---------------- Synchronisers, rts, errors ----------------
    logic w_set_frame, w_set_ovr, w_set_par;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_init   <= 1'b0;
            r_rts    <= 1'b0;
            r_cts_s1 <= 1'b0;
            r_cts_s2 <= 1'b0;
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_s3  <= 1'b1;
            r_err    <= 3'b000;
        end else begin
            r_init   <= 1'b1;
            r_rts    <= (c_DEPTH - w_rx_count) > c_MARGIN;
            r_cts_s1 <= cts;
            r_cts_s2 <= r_cts_s1;
            r_rx_s1  <= rx;
            r_rx_s2  <= r_rx_s1;
            r_rx_s3  <= r_rx_s2;
            // A set in the same cycle as err_clr wins
            r_err[ERR_FRAME]   <= w_set_frame | (r_err[ERR_FRAME]   & ~err_clr);
            r_err[ERR_OVERRUN] <= w_set_ovr   | (r_err[ERR_OVERRUN] & ~err_clr);
            r_err[ERR_PARITY]  <= w_set_par   | (r_err[ERR_PARITY]  & ~err_clr);
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t         r_tx_state, w_tx_next;
    logic [DIV_W-1:0]  r_tx_cnt, r_tx_div;
    logic [DATA_W-1:0] r_tx_shift;
    logic [c_BW-1:0]   r_tx_bit;
    logic              w_tx_tick;
`ifdef UART_PARITY_EN
    logic              r_tx_pen, r_tx_par;
`endif

    assign w_tx_tick = (r_tx_cnt == r_tx_div);
    assign tx_busy   = (r_tx_state != TX_IDLE) | (w_tx_count != '0);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_tx_state <= TX_IDLE;
        else         r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        tx        = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_empty && r_cts_s2) begin
                    w_tx_next = TX_START;
                    w_tx_pop  = 1'b1;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (w_tx_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx = r_tx_shift[0];
                if (w_tx_tick && r_tx_bit == c_LAST) begin
`ifdef UART_PARITY_EN
                    w_tx_next = r_tx_pen ? TX_PARITY : TX_STOP;
`else
                    w_tx_next = TX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx = r_tx_par;
                if (w_tx_tick) w_tx_next = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (w_tx_tick) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_tx_pen   <= 1'b0;
            r_tx_par   <= 1'b0;
`endif
        end else if (w_tx_pop) begin
            r_tx_div   <= baud_div;
            r_tx_shift <= w_tx_head;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_tx_pen   <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
            r_tx_par   <= (^w_tx_head) ^ (parity_mode == PARITY_ODD);
`endif
        end else if (r_tx_state != TX_IDLE) begin
            if (w_tx_tick) begin
                r_tx_cnt <= '0;
                if (r_tx_state == TX_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 1'b1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t        r_rx_state, w_rx_next;
    logic [DIV_W-1:0] r_rx_cnt, r_rx_div, r_rx_half;
    logic [c_BW-1:0]  r_rx_bit;
    logic             w_rx_tick, w_rx_mid;
`ifdef UART_PARITY_EN
    logic             r_rx_pen, r_rx_odd;
`endif

    assign w_rx_tick = (r_rx_cnt == r_rx_div);
    assign w_rx_mid  = (r_rx_cnt == r_rx_half);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next   = r_rx_state;
        w_rx_push   = 1'b0;
        w_set_frame = 1'b0;
        w_set_ovr   = 1'b0;
        w_set_par   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_s3 && !r_rx_s2) w_rx_next = RX_START;
            end
            RX_START: begin
                if (w_rx_mid) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_rx_tick && r_rx_bit == c_LAST) begin
`ifdef UART_PARITY_EN
                    w_rx_next = r_rx_pen ? RX_PARITY : RX_STOP;
`else
                    w_rx_next = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (w_rx_tick) begin
                    w_rx_next = RX_STOP;
                    w_set_par = r_rx_s2 != ((^r_rx_shift) ^ r_rx_odd);
                end
            end
`endif
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_next = RX_IDLE;
                    if (!r_rx_s2)      w_set_frame = 1'b1;
                    else if (w_rx_full) w_set_ovr  = 1'b1;
                    else               w_rx_push   = 1'b1;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Mid-bit offset is (baud_div+1)/2 clocks, stored minus one for the compare
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= '0;
            r_rx_half  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
`ifdef UART_PARITY_EN
            r_rx_pen   <= 1'b0;
            r_rx_odd   <= 1'b0;
`endif
        end else if (r_rx_state == RX_IDLE) begin
            if (w_rx_next == RX_START) begin
                r_rx_div  <= baud_div;
                r_rx_half <= (baud_div - DIV_W'(1)) >> 1;
                r_rx_cnt  <= '0;
                r_rx_bit  <= '0;
`ifdef UART_PARITY_EN
                r_rx_pen  <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
                r_rx_odd  <= (parity_mode == PARITY_ODD);
`endif
            end
        end else if (r_rx_state == RX_START) begin
            r_rx_cnt <= w_rx_mid ? '0 : r_rx_cnt + 1'b1;
        end else if (w_rx_tick) begin
            r_rx_cnt <= '0;
            if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
        end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_flowctl_core.sv
// ============================================================================
// Module      : tb_uart_flowctl_core
// Description : Directed self-checking bench with TX/RX scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_flowctl_core;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 8;
    localparam int DIV_W      = 16;
    localparam int RTS_MARGIN = 2;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic [DIV_W-1:0]  baud_div = 16'd3;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic              rx = 1'b1;
    logic              tx;
    logic              cts = 1'b1;
    logic              rts;
    logic              err_clr = 1'b0;
    logic [2:0]        err_flags;
    logic              err;
    logic              tx_busy;
`ifdef UART_PARITY_EN
    logic [1:0]        parity_mode = 2'd0;
`endif

    int errors = 0;
    int checks = 0;
    int cur_div = 3;
    bit mon_en = 1'b1;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    uart_flowctl_core #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .RTS_MARGIN(RTS_MARGIN)
    ) dut (
        .clk(clk), .nReset(nReset), .baud_div(baud_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx(rx), .tx(tx), .cts(cts), .rts(rts),
`ifdef UART_PARITY_EN
        .parity_mode(parity_mode),
`endif
        .err_clr(err_clr), .err_flags(err_flags), .err(err), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_div(input int d);
        baud_div = DIV_W'(d);
        cur_div  = d;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        exp_tx.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Drives one serial frame; jit alternates slot lengths by -1/+1 clock
    task automatic send_rx(input logic [7:0] d, input logic stop_bit, input bit jit,
                           input bit with_par, input logic par_bit);
        logic [10:0] fr;
        int n, per, dur;
        per = cur_div + 1;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (with_par) begin
            fr[9] = par_bit;
            fr[10] = stop_bit;
            n = 11;
        end else begin
            fr[9] = stop_bit;
            n = 10;
        end
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            rx = fr[k];
            dur = per + (jit ? ((k % 2 == 0) ? -1 : 1) : 0);
            repeat (dur) @(negedge clk);
        end
        rx = 1'b1;
        repeat (per) @(negedge clk);
    endtask

    task automatic pop_rx(input string tag);
        int t = 0;
        logic [31:0] e;
        while (rx_valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, rx_valid, 1);
        if (exp_rx.size() > 0) e = {24'h0, exp_rx.pop_front()};
        else                   e = 32'hDEAD_BEEF;
        chk({tag, "_data"}, rx_data, e);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_tx_drain(input string tag, input int budget);
        int t = 0;
        while ((exp_tx.size() != 0 || tx_busy !== 1'b0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, exp_tx.size(), 0);
    endtask

    // TX monitor: samples every bit near its centre and pops the scoreboard
    always begin : tx_monitor
        logic [7:0]  b;
        logic        st, sp;
        logic [31:0] e;
        int          d;
        @(negedge clk);
        if (mon_en && nReset === 1'b1 && tx === 1'b0) begin
            d = cur_div;
            repeat ((d + 1) / 2) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (d + 1) @(negedge clk);
                b[i] = tx;
            end
            repeat (d + 1) @(negedge clk);
            sp = tx;
            if (exp_tx.size() > 0) e = {24'h0, exp_tx.pop_front()};
            else                   e = 32'hDEAD_BEEF;
            chk("tx_mon_start", st, 0);
            chk("tx_mon_data", b, e);
            chk("tx_mon_stop", sp, 1);
        end
    end

    initial begin : stim
        logic [9:0] fr;
        int t, n, lows;

        // Reset state
        set_div(3);
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_rts", rts, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_busy", tx_busy, 0);
        nReset = 1'b1;
        @(negedge clk);
        chk("post_rst_tx_ready", tx_ready, 1);
        chk("post_rst_rts", rts, 1);
        repeat (3) @(negedge clk);

        // A5 at divisor 3: every clock of the frame
        push_tx(8'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        t = 0;
        while (tx !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("a5_start", tx, 0);
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            chk("a5_bit", tx, fr[k / 4]);
        end
        @(negedge clk);
        chk("a5_busy_after_stop", tx_busy, 0);
        wait_tx_drain("a5_drain", 50);

        // cts low holds the queue
        cts = 1'b0;
        repeat (4) @(negedge clk);
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("cts_hold_tx_low_cycles", lows, 0);
        chk("cts_hold_busy", tx_busy, 1);
        cts = 1'b1;
        wait_tx_drain("cts_release_drain", 600);

        // Fill the TX FIFO while blocked
        cts = 1'b0;
        repeat (4) @(negedge clk);
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                tx_valid = 1'b1;
                tx_data  = 8'(8'h40 + i);
                exp_tx.push_back(8'(8'h40 + i));
                n++;
            end else begin
                tx_valid = 1'b0;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("fill_count", n, DEPTH);
        chk("fill_tx_ready", tx_ready, 0);
        cts = 1'b1;
        wait_tx_drain("fill_drain", 1500);

        // RX at divisor 7 with edge jitter, then a short glitch
        set_div(7);
        exp_rx.push_back(8'h3C);
        send_rx(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        pop_rx("rx_3c");
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_rx_valid", rx_valid, 0);
        chk("glitch_err_flags", err_flags, 0);

        // rts threshold and overrun
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) exp_rx.push_back(8'(8'h81 + 8'(i * 7)));
            send_rx(8'(8'h81 + 8'(i * 7)), 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == DEPTH - RTS_MARGIN - 2) chk("rts_above_margin", rts, 1);
            if (i == DEPTH - RTS_MARGIN - 1) chk("rts_at_margin", rts, 0);
            if (i == DEPTH - 1)              chk("full_no_overrun", err_flags, 0);
        end
        chk("overrun_flags", err_flags, 3'b010);
        chk("overrun_err", err, 1);
        for (int i = 0; i < DEPTH; i++) pop_rx("ovr_pop");
        @(negedge clk);
        chk("ovr_drained", rx_valid, 0);
        chk("ovr_scoreboard_empty", exp_rx.size(), 0);
        clear_errs();
        @(negedge clk);
        chk("clr_err_flags", err_flags, 0);
        chk("clr_err", err, 0);
        chk("rts_restored", rts, 1);

        // Framing error
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("frame_flags", err_flags, 3'b001);
        chk("frame_no_push", rx_valid, 0);
        clear_errs();

        // Reset in the middle of a TX frame with a byte sitting in RX
        send_rx(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        set_div(3);
        push_tx(8'h99);
        push_tx(8'h66);
        t = 0;
        while (tx !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk("midframe_tx_low", tx, 0);
        nReset = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_rx_valid", rx_valid, 0);
        chk("async_rst_tx_busy", tx_busy, 0);
        chk("async_rst_tx_ready", tx_ready, 0);
        exp_tx.delete();
        exp_rx.delete();
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("post_rst_tx_idle", lows, 0);
        chk("post_rst_fifo_empty", tx_busy, 0);
        chk("post_rst_rx_empty", rx_valid, 0);

`ifdef UART_PARITY_EN
        // Even parity on TX, corrupted parity on RX
        parity_mode = 2'd1;
        push_tx(8'h07);
        exp_tx.delete();
        t = 0;
        while (tx !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (38) @(negedge clk);
        chk("tx_parity_bit", tx, 1);
        repeat (4) @(negedge clk);
        chk("tx_parity_stop", tx, 1);
        repeat (10) @(negedge clk);
        exp_rx.push_back(8'h3C);
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("rx_parity_flag", err_flags[2], 1);
        pop_rx("rx_parity_push");
        parity_mode = 2'd0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
